kernel_line_buffer: RTL and testbench

//  Feeds the kernel window. Accepts a raster pixel stream, one pixel per handshake.

---
 rtl/kernel_line_buffer_pkg.sv | 18 +
 rtl/kernel_line_buffer_line_ram.sv | 36 +++
 rtl/kernel_line_buffer.sv | 135 +++++++++++++
 tb/tb_kernel_line_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_line_buffer_pkg.sv
// Shared definitions for the kernel line buffer slice.
//  - Default geometry (pixel width, kernel block size, image size).
//  - lane_lsb(): bit offset of a lane inside a packed column. The kernel uses
//    the same helper, so the lane order cannot drift between producer and consumer.
package kernel_line_buffer_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_BLOCK_WIDTH  = 3;
  localparam int DEF_BLOCK_HEIGHT = 3;
  localparam int DEF_IMG_WIDTH    = 640;
  localparam int DEF_IMG_HEIGHT   = 480;

  // Lane 0 (the oldest image line) occupies the least significant bits.
  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/kernel_line_buffer_line_ram.sv
// line_ram: storage for one image line.
//  - One synchronous write port.
//  - Combinational read at the same address.
// Ports:
//  clk    input  1           write clock, rising edge
//  we     input  1           write enable
//  addr   input  ADDR_W      column address (shared by read and write)
//  wdata  input  DATA_WIDTH  write data
//  rdata  output DATA_WIDTH  combinational read data at addr (value before this cycle's write)
module line_ram
  import kernel_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMG_WIDTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset. Priming overwrites every entry before
  // it can reach the output.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/kernel_line_buffer.sv
// kernel_line_buffer: turns a raster pixel stream into vertical columns of
// BLOCK_HEIGHT pixels, one column per accepted pixel once the first
// BLOCK_HEIGHT-1 lines of a frame have been stored.
// Ports:
//  clk         input  1             system clock, rising edge
//  rst         input  1             asynchronous reset, active low
//  in_pixel    input  DATA_WIDTH    raster pixel, row-major
//  in_valid    input  1             in_pixel valid
//  in_ready    output 1             pixel accepted when in_valid & in_ready
//  out_pixels  output OUTPUT_WIDTH  packed column; lane 0 = oldest (top) line
//  out_valid   output BLOCK_HEIGHT  per-lane valid, all bits equal
//  out_ready   input  BLOCK_HEIGHT  per-lane ready; a column moves only when all lanes are ready
//  out_eol     output 1             column is the last one of its line
//  frame_done  output 1             pulses on transfer of the frame's last column
module kernel_line_buffer
  import kernel_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] out_pixels,
  output logic [BLOCK_HEIGHT-1:0] out_valid,
  input  logic [BLOCK_HEIGHT-1:0] out_ready,
  output logic                    out_eol,
  output logic                    frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int NL = BLOCK_HEIGHT - 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PRIMED = RW'(BLOCK_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          priming;
  logic          accept;
  logic          fire;
  logic          load;

  logic [DATA_WIDTH-1:0]   line_rd [NL];
  logic [DATA_WIDTH-1:0]   line_wr [NL];
  logic [OUTPUT_WIDTH-1:0] column_p0;

  logic [OUTPUT_WIDTH-1:0] pix_p1;
  logic                    vld_p1;
  logic                    eol_p1;
  logic                    last_p1;

  // A column transfers only when every lane is ready. in_ready is
  // combinational: a held column blocks input unless it leaves this cycle.
  assign fire     = vld_p1 & (&out_ready);
  assign in_ready = ~vld_p1 | fire;
  assign accept   = in_valid & in_ready;
  assign priming  = (row < ROW_PRIMED);
  assign load     = accept & ~priming;

  // ---- stage 0: line storage read and shift-write at the current column ----
  // Each accepted pixel moves every stored line up by one at this column.
  // The oldest value falls off the top and in_pixel enters as the newest line.
  for (genvar k = 0; k < NL; k++) begin : g_line
    line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_W     (CW)
    ) u_line_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (line_wr[k]),
      .rdata (line_rd[k])
    );

    if (k == NL - 1) begin : g_newest
      assign line_wr[k] = in_pixel;
    end else begin : g_older
      assign line_wr[k] = line_rd[k+1];
    end

    assign column_p0[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = line_rd[k];
  end

  assign column_p0[lane_lsb(NL, DATA_WIDTH) +: DATA_WIDTH] = in_pixel;

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---- stage 1: output column register ----
  // A new load wins over fire. That gives back-to-back columns when the
  // current column leaves in the same cycle. Without a new load, the column
  // holds until it transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_p1  <= '0;
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      pix_p1  <= column_p0;
      vld_p1  <= 1'b1;
      eol_p1  <= (col == COL_LAST);
      last_p1 <= (col == COL_LAST) && (row == ROW_LAST);
    end else if (fire) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_pixels = pix_p1;
  assign out_valid  = {BLOCK_HEIGHT{vld_p1}};
  assign out_eol    = eol_p1;
  assign frame_done = fire & last_p1;

endmodule

// File: tb/tb_kernel_line_buffer.sv
// Bench for kernel_line_buffer with a 4x4 image and 3-line window.
// The reference model keeps the frame as a 2-D array. Each accepted pixel
// at row r >= 2 queues the column of the three newest lines at that image
// column. The compare process checks the DUT against the head of that queue
// on every cycle.
module tb_kernel_line_buffer;

  localparam int DW = 8;
  localparam int BH = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int OW = DW * BH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_pixels;
  logic [BH-1:0] out_valid;
  logic [BH-1:0] out_ready = 3'b111;
  logic          out_eol;
  logic          frame_done;

  kernel_line_buffer #(
    .DATA_WIDTH   (DW),
    .BLOCK_HEIGHT (BH),
    .IMG_WIDTH    (IW),
    .IMG_HEIGHT   (IH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pixels (out_pixels),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  typedef struct packed {
    logic [OW-1:0] pix;
    logic          eol;
    logic          last;
  } col_t;

  logic [DW-1:0] img [IH][IW];
  col_t          q[$];
  int            m_r = 0;
  int            m_c = 0;

  always @(negedge clk) begin
    bit   have;
    bit   all_rdy;
    bit   exp_rdy;
    col_t nc;
    if (!rst) begin
      q.delete();
      m_r = 0;
      m_c = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pixels", out_pixels, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_out_eol", out_eol, 0);
    end else begin
      have    = (q.size() != 0);
      all_rdy = &out_ready;
      exp_rdy = !have || all_rdy;
      chk("out_valid", out_valid, {BH{have}});
      chk("in_ready", in_ready, exp_rdy);
      if (have) begin
        chk("out_pixels", out_pixels, q[0].pix);
        chk("out_eol", out_eol, q[0].eol);
        chk("frame_done", frame_done, all_rdy && q[0].last);
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      if (have && all_rdy) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        img[m_r][m_c] = in_pixel;
        if (m_r >= BH - 1) begin
          for (int k = 0; k < BH; k++) nc.pix[k*DW +: DW] = img[m_r-(BH-1)+k][m_c];
          nc.eol  = (m_c == IW - 1);
          nc.last = (m_r == IH - 1) && (m_c == IW - 1);
          q.push_back(nc);
        end
        if (m_c == IW - 1) begin
          m_c = 0;
          m_r = (m_r == IH - 1) ? 0 : m_r + 1;
        end else begin
          m_c++;
        end
      end
    end
  end

  // Transfers seen on the output, used for per-frame column counts.
  int fires = 0;
  always @(posedge clk) if (rst && out_valid[0] && (&out_ready)) fires++;

  // Random backpressure, enabled per phase.
  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
  end

  // ---------------- driver ----------------
  int d_r = 0;
  int d_c = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents p and returns #1 after the edge that accepts it. in_valid is left
  // high, so the caller either presents the next pixel or drops it.
  task automatic send(input logic [DW-1:0] p);
    int budget;
    budget = 200;
    in_valid = 1'b1;
    in_pixel = p;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept at %0t", $time);
    end
    tick();
    if (d_c == IW - 1) begin
      d_c = 0;
      d_r = (d_r == IH - 1) ? 0 : d_r + 1;
    end else begin
      d_c++;
    end
  endtask

  task automatic send_px(input int base);
    send(DW'(base + d_r * 16 + d_c));
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    tick();
    out_ready = 3'b111;
    repeat (3) tick();
  endtask

  int f0;

  initial begin
    // 1. reset
    repeat (3) tick();
    chk("t1_valid", out_valid, 3'b000);
    chk("t1_pixels", out_pixels, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_frame_done", frame_done, 0);
    rst = 1'b1;
    tick();

    // 2./3. first frame, in_valid held high, full ready
    f0 = fires;
    for (int i = 0; i < IW * IH; i++) begin
      send_px(0);
      if (i < 8) chk("t2_priming_valid", out_valid, 3'b000);
      if (i == 8) begin
        chk("t2_first_valid", out_valid, 3'b111);
        chk("t2_first_col", out_pixels, 24'h201000);
        chk("t2_first_eol", out_eol, 0);
      end
      if (i == 11) begin
        chk("t3_row2_last_col", out_pixels, 24'h231303);
        chk("t3_row2_eol", out_eol, 1);
      end
      if (i == 15) begin
        chk("t3_last_col", out_pixels, 24'h332313);
        chk("t3_last_eol", out_eol, 1);
        chk("t3_frame_done", frame_done, 1);
      end
    end
    drain();
    chk("t3_columns", fires - f0, 8);

    // 4./5. second frame with a partial-ready hold on its first column
    f0 = fires;
    for (int i = 0; i < 8; i++) send_px(8'h80);
    chk("t5_priming_valid", out_valid, 3'b000);
    out_ready = 3'b101;
    send_px(8'h80);
    in_pixel = 8'hA1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_pixels", out_pixels, 24'hA09080);
      chk("t4_hold_valid", out_valid, 3'b111);
      chk("t4_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 3'b111;
    send_px(8'h80);
    chk("t4_one_transfer", fires - f0, 1);
    chk("t4_next_col", out_pixels, 24'hA19181);
    rand_ready = 1'b1;
    while (!(d_r == 0 && d_c == 0)) begin
      maybe_gap();
      send_px(8'h80);
    end
    drain();
    chk("t5_columns", fires - f0, 8);

    // 6. reset with a column pending
    for (int i = 0; i < 13; i++) send(DW'($urandom_range(0, 255)));
    in_valid  = 1'b0;
    out_ready = 3'b000;
    chk("t6_pending_valid", out_valid, 3'b111);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 3'b000);
    chk("t6_async_pixels", out_pixels, 0);
    tick();
    tick();
    rst = 1'b1;
    d_r = 0;
    d_c = 0;
    out_ready = 3'b111;
    tick();
    f0 = fires;
    for (int i = 0; i < 8; i++) send_px(8'h40);
    chk("t6_priming_valid", out_valid, 3'b000);
    send_px(8'h40);
    chk("t6_first_col", out_pixels, 24'h605040);
    rand_ready = 1'b1;
    while (!(d_r == 0 && d_c == 0)) begin
      maybe_gap();
      send_px(8'h40);
    end
    drain();
    chk("t6_columns", fires - f0, 8);

    // random frames under random backpressure and input gaps
    for (int fr = 0; fr < 2; fr++) begin
      f0 = fires;
      rand_ready = 1'b1;
      for (int i = 0; i < IW * IH; i++) begin
        maybe_gap();
        send(DW'($urandom_range(0, 255)));
      end
      drain();
      chk("rand_columns", fires - f0, 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
